// File: rtl/noc_pkg.sv
// Shared NoC packet layout, source/sequence field helpers and throttle LFSR constants
// used by both the traffic-generating client and the sink client.
package noc_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int v_pos(input int a_w, input int d_w);
    return a_w + d_w + 1;
  endfunction

  function automatic int l_pos(input int a_w, input int d_w);
    return a_w + d_w;
  endfunction

  function automatic int addr_lsb(input int d_w);
    return d_w;
  endfunction

  // Source id sits in the top S_W bits of the payload, sequence in the bottom SEQ_W
  function automatic int src_lsb(input int d_w, input int s_w);
    return d_w - s_w;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/sink_fifo.sv
// Registered-pointer FIFO; pointers carry an extra wrap bit so full/empty/count
// come straight from the pointer difference.
module sink_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [W-1:0]         wdata,
  input  logic                 pop,
  output logic [W-1:0]         rdata,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(D):0]   count
);

  localparam int AW = $clog2(D);

  logic [W-1:0] mem [D];
  logic [AW:0]  wr_ptr, rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(D));
  assign empty = (wr_ptr == rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointer reset discards the contents
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bft_sink_client.sv
// BFT leaf sink: buffers network packets, drains them at an LFSR-throttled rate,
// checks destination and per-source sequence numbers, and counts deliveries.
module bft_sink_client
  import noc_pkg::*;
#(
  parameter int N      = 4,
  parameter int D_W    = 32,
  parameter int A_W    = $clog2(N) + 1,
  parameter int ID     = 0,
  parameter int LIMIT  = 512,
  parameter int RATE   = 128,
  parameter int FIFO_D = 4,
  parameter int SEQ_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [A_W+D_W+1:0]   in_pkt,
  output logic                 in_bp,
  output logic [31:0]          rx_cnt,
  output logic [15:0]          err_cnt,
  output logic                 ovf_err,
  output logic                 done
);

  localparam int S_W    = (N > 1) ? $clog2(N) : 1;
  localparam int W      = A_W + D_W;
  localparam int CW     = $clog2(FIFO_D) + 1;
  localparam int V_POS  = v_pos(A_W, D_W);
  localparam int L_POS  = l_pos(A_W, D_W);
  localparam int A_LSB  = addr_lsb(D_W);
  localparam int S_LSB  = src_lsb(D_W, S_W);
  localparam logic DRAIN_ALL = (RATE >= 128);

  logic              in_v;
  logic              full, empty, push, pop;
  logic [CW-1:0]     count, occ_next;
  logic [W-1:0]      head;
  logic [A_W-1:0]    head_addr;
  logic [D_W-1:0]    head_data;
  logic [S_W-1:0]    src;
  logic [SEQ_W-1:0]  seq;
  logic [15:0]       lfsr;
  logic              drain_ok;
  logic              addr_err, seq_err;
  logic [16:0]       err_sum;
  logic [32:0]       rx_next;
  logic [SEQ_W-1:0]  exp_seq [N];
  logic              unused_bits;

  assign in_v      = in_pkt[V_POS];
  assign drain_ok  = DRAIN_ALL | ({1'b0, lfsr[6:0]} < 8'(RATE));
  assign pop       = ce & ~empty & drain_ok;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands
  assign push      = ce & in_v & (~full | pop);
  assign occ_next  = count + CW'(push) - CW'(pop);

  sink_fifo #(.W(W), .D(FIFO_D)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_pkt[W-1:0]),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign head_addr = head[A_LSB +: A_W];
  assign head_data = head[D_W-1:0];
  assign src       = head_data[S_LSB +: S_W];
  assign seq       = head_data[SEQ_W-1:0];
  assign addr_err  = (head_addr != A_W'(ID));
  assign seq_err   = (seq != exp_seq[src]);
  assign err_sum   = {1'b0, err_cnt} + 17'(addr_err) + 17'(seq_err);
  assign rx_next   = {1'b0, rx_cnt} + 33'd1;

  // The last flag and the payload bits between source id and sequence are don't-care
  assign unused_bits = ^{in_pkt[L_POS], head_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      in_bp   <= 1'b0;
      rx_cnt  <= '0;
      err_cnt <= '0;
      ovf_err <= 1'b0;
      done    <= 1'b0;
      lfsr    <= LFSR_SEED;
      for (int i = 0; i < N; i++) exp_seq[i] <= '0;
    end else if (ce) begin
      lfsr  <= lfsr_next(lfsr);
      in_bp <= (occ_next >= CW'(FIFO_D - 1));
      if (in_v && full && !pop) ovf_err <= 1'b1;
      if (pop) begin
        // Resync on mismatch so one dropped packet costs a single error
        exp_seq[src] <= seq + 1'b1;
        err_cnt      <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        rx_cnt       <= rx_next[32] ? 32'hFFFF_FFFF : rx_next[31:0];
        if (rx_next == 33'(LIMIT)) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bft_sink_client.sv
// Scoreboarded bench for bft_sink_client: three instances cover full-rate checking,
// a small LIMIT, and a never-draining sink for backpressure/overflow/reset.
module tb_bft_sink_client;

  typedef struct packed {
    logic [31:0] rx;
    logic [15:0] err;
    logic        done;
  } exp_t;

  logic clk;
  logic rst_a, rst_b, rst_c;
  logic ce_a, ce_b, ce_c;
  logic [36:0] pkt_a, pkt_b, pkt_c;
  logic        bp_a, bp_b, bp_c;
  logic [31:0] rx_a, rx_b, rx_c;
  logic [15:0] err_a, err_b, err_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic        done_a, done_b, done_c;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic bp_seen_a;

  bft_sink_client #(.ID(2), .RATE(128), .LIMIT(512)) dut_a (
    .clk(clk), .rst(rst_a), .ce(ce_a), .in_pkt(pkt_a), .in_bp(bp_a),
    .rx_cnt(rx_a), .err_cnt(err_a), .ovf_err(ovf_a), .done(done_a));

  bft_sink_client #(.ID(2), .RATE(128), .LIMIT(8)) dut_b (
    .clk(clk), .rst(rst_b), .ce(ce_b), .in_pkt(pkt_b), .in_bp(bp_b),
    .rx_cnt(rx_b), .err_cnt(err_b), .ovf_err(ovf_b), .done(done_b));

  bft_sink_client #(.ID(0), .RATE(0), .FIFO_D(4)) dut_c (
    .clk(clk), .rst(rst_c), .ce(ce_c), .in_pkt(pkt_c), .in_bp(bp_c),
    .rx_cnt(rx_c), .err_cnt(err_c), .ovf_err(ovf_c), .done(done_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [36:0] mk(input logic [2:0] addr, input logic [1:0] src,
                                     input logic [15:0] seq);
    return {1'b1, 1'b0, addr, src, 14'b0, seq};
  endfunction

  task automatic drive_a(input logic [36:0] p);
    pkt_a = p;
    @(posedge clk); #1;
    pkt_a = '0;
  endtask

  task automatic drive_b(input logic [36:0] p);
    pkt_b = p;
    @(posedge clk); #1;
    pkt_b = '0;
  endtask

  task automatic drive_c(input logic [36:0] p, input logic c);
    pkt_c = p;
    ce_c  = c;
    @(posedge clk); #1;
    pkt_c = '0;
    ce_c  = 1'b1;
  endtask

  task automatic pulse_rst_c();
    rst_c = 1'b1;
    @(posedge clk); #1;
    rst_c = 1'b0;
  endtask

  // Monitors: every change of rx_cnt is a delivery, compared against the next expectation
  initial begin : mon_a
    logic [31:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (bp_a === 1'b1) bp_seen_a = 1'b1;
      if (rx_a !== prev && !$isunknown(rx_a)) begin
        prev = rx_a;
        if (rx_a != 0) begin
          if (q_a.size() == 0) chk("a_unexpected_delivery", rx_a, 32'h0);
          else begin
            e = q_a.pop_front();
            chk("a_rx_cnt", rx_a, e.rx);
            chk("a_err_cnt", 32'(err_a), 32'(e.err));
            chk("a_done", 32'(done_a), 32'(e.done));
          end
        end
      end
    end
  end

  initial begin : mon_b
    logic [31:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rx_b !== prev && !$isunknown(rx_b)) begin
        prev = rx_b;
        if (rx_b != 0) begin
          if (q_b.size() == 0) chk("b_unexpected_delivery", rx_b, 32'h0);
          else begin
            e = q_b.pop_front();
            chk("b_rx_cnt", rx_b, e.rx);
            chk("b_err_cnt", 32'(err_b), 32'(e.err));
            chk("b_done", 32'(done_b), 32'(e.done));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] seqs [4];
    logic [15:0] errs [4];
    seqs = '{16'd0, 16'd1, 16'd3, 16'd4};
    errs = '{16'd0, 16'd0, 16'd1, 16'd1};
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ce_a = 1'b1; ce_b = 1'b1; ce_c = 1'b1;
    pkt_a = '0; pkt_b = '0; pkt_c = '0;
    bp_seen_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    chk("rst_rx_cnt", rx_a, 32'h0);
    chk("rst_err_cnt", 32'(err_a), 32'h0);
    chk("rst_in_bp", 32'(bp_a), 32'h0);
    chk("rst_ovf_err", 32'(ovf_c), 32'h0);
    chk("rst_done", 32'(done_b), 32'h0);

    // Full-rate in-order stream to the right address
    bp_seen_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      q_a.push_back('{rx: 32'(i + 1), err: 16'd0, done: 1'b0});
      drive_a(mk(3'd2, 2'd0, 16'(i)));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("t1_rx_cnt", rx_a, 32'd10);
    chk("t1_err_cnt", 32'(err_a), 32'd0);
    chk("t1_in_bp_seen", 32'(bp_seen_a), 32'd0);
    chk("t1_done", 32'(done_a), 32'd0);

    // LIMIT=8: done rises with the 8th delivery and stays up afterwards
    for (int i = 0; i < 11; i++) begin
      q_b.push_back('{rx: 32'(i + 1), err: 16'd0, done: (i >= 7)});
      drive_b(mk(3'd2, 2'd0, 16'(i)));
    end

    // Sequence gap on src1: one error at seq 3, then clean again
    for (int i = 0; i < 4; i++) begin
      q_a.push_back('{rx: 32'(11 + i), err: errs[i], done: 1'b0});
      drive_a(mk(3'd2, 2'd1, seqs[i]));
    end

    // Wrong address, then sequence wrap on src3 (first packet resyncs from 0)
    q_a.push_back('{rx: 32'd15, err: 16'd2, done: 1'b0});
    drive_a(mk(3'd1, 2'd2, 16'd0));
    q_a.push_back('{rx: 32'd16, err: 16'd3, done: 1'b0});
    drive_a(mk(3'd2, 2'd3, 16'hFFFF));
    q_a.push_back('{rx: 32'd17, err: 16'd3, done: 1'b0});
    drive_a(mk(3'd2, 2'd3, 16'h0000));
    repeat (3) @(posedge clk);
    #1;
    chk("t4_rx_cnt", rx_a, 32'd17);
    chk("t4_err_cnt", 32'(err_a), 32'd3);

    // Reset clears expected sequences: src0 restarts at 0 with no error
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    chk("a_rst_rx_cnt", rx_a, 32'd0);
    chk("a_rst_err_cnt", 32'(err_a), 32'd0);
    q_a.push_back('{rx: 32'd1, err: 16'd0, done: 1'b0});
    drive_a(mk(3'd2, 2'd0, 16'd0));

    // Never-draining sink: backpressure, slack slot, overflow
    drive_c(mk(3'd0, 2'd0, 16'd0), 1'b1);
    drive_c(mk(3'd0, 2'd0, 16'd1), 1'b1);
    chk("t5_in_bp_after2", 32'(bp_c), 32'd0);
    drive_c(mk(3'd0, 2'd0, 16'd2), 1'b1);
    chk("t5_in_bp_after3", 32'(bp_c), 32'd1);
    drive_c(mk(3'd0, 2'd0, 16'd3), 1'b1);
    chk("t5_ovf_after4", 32'(ovf_c), 32'd0);
    chk("t5_in_bp_after4", 32'(bp_c), 32'd1);
    drive_c(mk(3'd0, 2'd0, 16'd4), 1'b1);
    chk("t5_ovf_after5", 32'(ovf_c), 32'd1);
    chk("t5_rx_cnt", rx_c, 32'd0);

    // Fill two entries with ce toggling (ce=0 packet is ignored), then reset
    pulse_rst_c();
    chk("c_rst_ovf", 32'(ovf_c), 32'd0);
    chk("c_rst_in_bp", 32'(bp_c), 32'd0);
    drive_c(mk(3'd0, 2'd0, 16'd0), 1'b1);
    drive_c(mk(3'd0, 2'd0, 16'd1), 1'b0);
    drive_c(mk(3'd0, 2'd0, 16'd2), 1'b1);
    chk("t6_ce_low_ignored", 32'(bp_c), 32'd0);
    drive_c(mk(3'd0, 2'd0, 16'd3), 1'b0);
    pulse_rst_c();
    chk("t6_rst_in_bp", 32'(bp_c), 32'd0);
    chk("t6_rst_ovf", 32'(ovf_c), 32'd0);
    chk("t6_rst_rx", rx_c, 32'd0);
    chk("t6_rst_err", 32'(err_c), 32'd0);
    chk("t6_rst_done", 32'(done_c), 32'd0);
    drive_c(mk(3'd0, 2'd0, 16'd0), 1'b1);
    drive_c(mk(3'd0, 2'd0, 16'd1), 1'b1);
    chk("t6_fifo_emptied", 32'(bp_c), 32'd0);
    drive_c(mk(3'd0, 2'd0, 16'd2), 1'b1);
    chk("t6_in_bp_refill", 32'(bp_c), 32'd1);

    for (int i = 0; i < 50 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
    #1;
    chk("a_queue_drained", 32'(q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);
    chk("b_done_final", 32'(done_b), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
